// File: rtl/dp_sink_aux_pkg.sv
// Shared types and constants for the sink-side AUX request responder.
// Holds command/reply encodings, the FSM state type and the request check.
package dp_sink_aux_pkg;

  localparam int AUX_ADDRESS_WIDTH = 20;
  localparam int AUX_DATA_WIDTH    = 8;
  localparam int MAX_BURST         = 16;
  localparam int CNT_W             = $clog2(MAX_BURST + 1);

  localparam logic [AUX_ADDRESS_WIDTH-1:0] DPCD_MAX_ADDR = 20'h00FFF;

  localparam logic [3:0] CMD_NATIVE_WR = 4'b1000;
  localparam logic [3:0] CMD_NATIVE_RD = 4'b1001;

  localparam logic [7:0] REPLY_ACK      = 8'h00;
  localparam logic [7:0] REPLY_NACK     = 8'h10;
  localparam logic [7:0] REPLY_DEFER    = 8'h20;
  localparam logic [7:0] REPLY_I2C_NACK = 8'h40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_DRAIN,
    ST_CHECK,
    ST_WCOMMIT,
    ST_RFETCH,
    ST_REPLY_CMD,
    ST_REPLY_DATA
  } state_t;

  // Ordered request validation; earlier failures mask later ones.
  function automatic logic [7:0] aux_check(
    input logic [3:0]                 cmd,
    input logic [AUX_ADDRESS_WIDTH:0] end_addr,
    input logic [CNT_W-1:0]           cnt,
    input logic                       ovf,
    input logic [CNT_W-1:0]           len,
    input logic                       busy
  );
    logic len_bad;
    len_bad = ovf ||
      ((cmd == CMD_NATIVE_WR) ? (cnt != len) : (cnt != '0));
    if (!cmd[3])
      return REPLY_I2C_NACK;
    if (cmd != CMD_NATIVE_WR && cmd != CMD_NATIVE_RD)
      return REPLY_NACK;
    if (end_addr > {1'b0, DPCD_MAX_ADDR})
      return REPLY_NACK;
    if (len_bad)
      return REPLY_NACK;
    if (busy)
      return REPLY_DEFER;
    return REPLY_ACK;
  endfunction

endpackage

// File: rtl/dp_sink_aux_responder_if.sv
// Request/reply byte streams and DPCD register port of the AUX responder.
// The responder attaches as slave; the AUX PHY/encoder/regfile side as master.
interface dp_sink_aux_responder_if;
  import dp_sink_aux_pkg::*;

  logic [AUX_DATA_WIDTH-1:0]    RX_Byte;
  logic                         RX_Byte_VLD;
  logic                         RX_Frame_End;
  logic [AUX_DATA_WIDTH-1:0]    TX_Byte;
  logic                         TX_Byte_VLD;
  logic                         TX_Byte_RDY;
  logic                         TX_Last;
  logic [AUX_ADDRESS_WIDTH-1:0] REG_Addr;
  logic [AUX_DATA_WIDTH-1:0]    REG_WData;
  logic                         REG_WR;
  logic                         REG_RD;
  logic [AUX_DATA_WIDTH-1:0]    REG_RData;
  logic                         REG_Busy;
  logic                         Resp_Busy;

  modport slave (
    input  RX_Byte, RX_Byte_VLD, RX_Frame_End,
    input  TX_Byte_RDY, REG_RData, REG_Busy,
    output TX_Byte, TX_Byte_VLD, TX_Last,
    output REG_Addr, REG_WData, REG_WR, REG_RD,
    output Resp_Busy
  );

  modport master (
    output RX_Byte, RX_Byte_VLD, RX_Frame_End,
    output TX_Byte_RDY, REG_RData, REG_Busy,
    input  TX_Byte, TX_Byte_VLD, TX_Last,
    input  REG_Addr, REG_WData, REG_WR, REG_RD,
    input  Resp_Busy
  );

endinterface

// File: rtl/dp_aux_burst_buffer.sv
// Small byte FIFO holding one native burst (write data or read data).
// Clear wins over any same-cycle write or read.
module dp_aux_burst_buffer
  import dp_sink_aux_pkg::*;
#(
  parameter int DEPTH = MAX_BURST,
  parameter int W     = AUX_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok   = wr_en && !clear && (count < CW'(DEPTH));
  assign rd_ok   = rd_en && !clear && (count != '0);
  assign rd_data = mem[rptr];

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok)
        wptr <= inc(wptr);
      if (rd_ok)
        rptr <= inc(rptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dp_sink_aux_responder.sv
// Sink AUX native request responder: parses request bytes, accesses DPCD
// registers and streams the ACK/NACK/DEFER reply plus read data.
module dp_sink_aux_responder
  import dp_sink_aux_pkg::*;
(
  input logic                    clk,
  input logic                    reset_n,
  dp_sink_aux_responder_if.slave aux
);

  localparam int AW  = AUX_ADDRESS_WIDTH;
  localparam int AW1 = AUX_ADDRESS_WIDTH + 1;
  localparam int DW  = AUX_DATA_WIDTH;

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     hcnt_q;
  logic [3:0]     cmd_q;
  logic [AW-1:0]  addr_q;
  logic [3:0]     len_m1_q;
  logic [CNT_W-1:0] idx_q;
  logic           ovf_q;
  logic [7:0]     code_q;
  logic           rd_ack_q;
  logic           rd_pend_q;

  logic           vld;
  logic           fe;
  logic [CNT_W-1:0] len;
  logic [AW:0]    end_addr;
  logic [AW-1:0]  cur_addr;
  logic [7:0]     chk_code;

  logic           buf_clr;
  logic           buf_wr;
  logic           buf_rd;
  logic [DW-1:0]  buf_wdata;
  logic [DW-1:0]  buf_rdata;
  logic [CNT_W-1:0] buf_cnt;

  logic [DW-1:0]  tx_byte;
  logic           tx_vld;
  logic           tx_last;
  logic [AW-1:0]  reg_addr;
  logic [DW-1:0]  reg_wdata;
  logic           reg_wr;
  logic           reg_rd;

  assign vld      = aux.RX_Byte_VLD;
  assign fe       = aux.RX_Frame_End;
  assign len      = CNT_W'(len_m1_q) + CNT_W'(1);
  assign end_addr = {1'b0, addr_q} + AW1'(len_m1_q);
  assign cur_addr = addr_q + AW'(idx_q);
  assign chk_code = aux_check(cmd_q, end_addr, buf_cnt, ovf_q,
                              len, aux.REG_Busy);

  dp_aux_burst_buffer #(
    .DEPTH (MAX_BURST),
    .W     (DW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear   (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (buf_wdata),
    .rd_en   (buf_rd),
    .rd_data (buf_rdata),
    .count   (buf_cnt)
  );

  always_comb begin
    state_d   = state_q;
    buf_clr   = 1'b0;
    buf_wr    = 1'b0;
    buf_rd    = 1'b0;
    buf_wdata = aux.RX_Byte;
    tx_byte   = '0;
    tx_vld    = 1'b0;
    tx_last   = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (vld) begin
          buf_clr = 1'b1;
          if (!fe)
            state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (fe)
          state_d = (vld && hcnt_q == 2'd3) ? ST_CHECK : ST_IDLE;
        else if (vld && hcnt_q == 2'd3)
          state_d = ST_WDATA;
      end
      ST_WDATA: begin
        // Bytes past a full burst are dropped; the overflow forces a NACK.
        if (vld) begin
          if (buf_cnt == CNT_W'(MAX_BURST))
            state_d = ST_DRAIN;
          else
            buf_wr = 1'b1;
        end
        if (fe)
          state_d = ST_CHECK;
      end
      ST_DRAIN: begin
        if (fe)
          state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (chk_code != REPLY_ACK)
          state_d = ST_REPLY_CMD;
        else if (cmd_q == CMD_NATIVE_WR)
          state_d = ST_WCOMMIT;
        else
          state_d = ST_RFETCH;
      end
      ST_WCOMMIT: begin
        reg_wr    = 1'b1;
        reg_addr  = cur_addr;
        reg_wdata = buf_rdata;
        buf_rd    = 1'b1;
        if (idx_q == CNT_W'(len_m1_q))
          state_d = ST_REPLY_CMD;
      end
      ST_RFETCH: begin
        // Issue runs one cycle ahead of capture; idx == len is the tail capture.
        if (idx_q < len) begin
          reg_rd   = 1'b1;
          reg_addr = cur_addr;
        end
        buf_wr    = rd_pend_q;
        buf_wdata = aux.REG_RData;
        if (idx_q == len)
          state_d = ST_REPLY_CMD;
      end
      ST_REPLY_CMD: begin
        tx_byte = code_q;
        tx_vld  = 1'b1;
        tx_last = !rd_ack_q;
        if (aux.TX_Byte_RDY)
          state_d = rd_ack_q ? ST_REPLY_DATA : ST_IDLE;
      end
      ST_REPLY_DATA: begin
        tx_byte = buf_rdata;
        tx_vld  = 1'b1;
        tx_last = (idx_q == CNT_W'(len_m1_q));
        if (aux.TX_Byte_RDY) begin
          buf_rd = 1'b1;
          if (tx_last)
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      len_m1_q  <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      code_q    <= '0;
      rd_ack_q  <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= reg_rd;
      case (state_q)
        ST_IDLE: begin
          if (vld) begin
            cmd_q              <= aux.RX_Byte[7:4];
            addr_q[AW-1 -: 4]  <= aux.RX_Byte[3:0];
            hcnt_q             <= 2'd1;
            ovf_q              <= 1'b0;
          end
        end
        ST_HDR: begin
          if (vld) begin
            hcnt_q <= hcnt_q + 1'b1;
            case (hcnt_q)
              2'd1:    addr_q[15:8] <= aux.RX_Byte;
              2'd2:    addr_q[7:0]  <= aux.RX_Byte;
              2'd3:    len_m1_q     <= aux.RX_Byte[3:0];
              default: ;
            endcase
          end
        end
        ST_WDATA: begin
          if (vld && buf_cnt == CNT_W'(MAX_BURST))
            ovf_q <= 1'b1;
        end
        ST_CHECK: begin
          code_q   <= chk_code;
          rd_ack_q <= (chk_code == REPLY_ACK) &&
                      (cmd_q == CMD_NATIVE_RD);
          idx_q    <= '0;
        end
        ST_WCOMMIT, ST_RFETCH: begin
          idx_q <= (state_d == ST_REPLY_CMD) ? '0 : idx_q + 1'b1;
        end
        ST_REPLY_DATA: begin
          if (aux.TX_Byte_RDY)
            idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign aux.TX_Byte     = tx_byte;
  assign aux.TX_Byte_VLD = tx_vld;
  assign aux.TX_Last     = tx_last;
  assign aux.REG_Addr    = reg_addr;
  assign aux.REG_WData   = reg_wdata;
  assign aux.REG_WR      = reg_wr;
  assign aux.REG_RD      = reg_rd;
  assign aux.Resp_Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dp_sink_aux_responder.sv
// Directed bench for dp_sink_aux_responder with a byte-wide DPCD model.
// Logs register and reply traffic and compares against hand-written vectors.
module tb_dp_sink_aux_responder;

  logic clk;
  logic reset_n;

  dp_sink_aux_responder_if aux ();

  dp_sink_aux_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .aux     (aux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  int fe_cyc;
  int first_vld;

  logic [7:0]  mem [256];
  logic [7:0]  req [$];
  logic [8:0]  tx_log [$];
  logic [27:0] wr_log [$];
  logic [19:0] rd_log [$];
  logic [8:0]  exp_tx [$];
  logic [27:0] exp_wr [$];
  logic [19:0] exp_rd [$];

  logic        rd_seen = 1'b0;
  logic [19:0] rd_a    = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    rd_seen = aux.REG_RD;
    rd_a    = aux.REG_Addr;
    if (aux.REG_WR)
      wr_log.push_back({aux.REG_Addr, aux.REG_WData});
    if (aux.REG_RD)
      rd_log.push_back(aux.REG_Addr);
    if (aux.TX_Byte_VLD && aux.TX_Byte_RDY)
      tx_log.push_back({aux.TX_Last, aux.TX_Byte});
    if (aux.TX_Byte_VLD && first_vld < 0)
      first_vld = cyc;
  end

  always @(posedge clk) begin
    #1;
    aux.REG_RData = rd_seen ? mem[rd_a[7:0]] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, aux.TX_Byte_VLD, aux.TX_Last,
        aux.REG_WR, aux.REG_RD, aux.Resp_Busy}, 32'd0);
    chk({tag, "_addr"}, {12'd0, aux.REG_Addr}, 32'd0);
    chk({tag, "_data"}, {16'd0, aux.TX_Byte, aux.REG_WData}, 32'd0);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    wr_log.delete();
    rd_log.delete();
    first_vld = -1;
  endtask

  task automatic send();
    clear_logs();
    foreach (req[i]) begin
      @(posedge clk); #1;
      aux.RX_Byte      = req[i];
      aux.RX_Byte_VLD  = 1'b1;
      aux.RX_Frame_End = (i == req.size() - 1);
      if (i == req.size() - 1)
        fe_cyc = cyc;
    end
    @(posedge clk); #1;
    aux.RX_Byte      = 8'h00;
    aux.RX_Byte_VLD  = 1'b0;
    aux.RX_Frame_End = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((aux.Resp_Busy || aux.TX_Byte_VLD) && n < 200);
    if (n >= 200)
      chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      chk({tag, "_tx"}, {23'd0, tx_log[i]}, {23'd0, exp_tx[i]});
    chk({tag, "_nwr"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      chk({tag, "_wr"}, {4'd0, wr_log[i]}, {4'd0, exp_wr[i]});
    chk({tag, "_nrd"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      chk({tag, "_rd"}, {12'd0, rd_log[i]}, {12'd0, exp_rd[i]});
  endtask

  task automatic run(input string tag);
    send();
    wait_idle();
    check_logs(tag);
  endtask

  task automatic stall_byte(input string tag);
    int n = 0;
    logic [8:0] snap;
    logic ok;
    do begin
      @(negedge clk);
      n++;
    end while (!aux.TX_Byte_VLD && n < 50);
    snap = {aux.TX_Last, aux.TX_Byte};
    ok = aux.TX_Byte_VLD;
    repeat (5) begin
      @(negedge clk);
      if (!aux.TX_Byte_VLD || {aux.TX_Last, aux.TX_Byte} !== snap)
        ok = 1'b0;
    end
    chk(tag, {31'd0, ok}, 32'd1);
    @(posedge clk); #1 aux.TX_Byte_RDY = 1'b1;
    @(posedge clk); #1 aux.TX_Byte_RDY = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h12;
    mem[1] = 8'h0A;
    mem[2] = 8'h84;

    reset_n          = 1'b0;
    aux.RX_Byte      = 8'h00;
    aux.RX_Byte_VLD  = 1'b0;
    aux.RX_Frame_End = 1'b0;
    aux.TX_Byte_RDY  = 1'b1;
    aux.REG_RData    = 8'h00;
    aux.REG_Busy     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Native read 0x00000, 3 bytes
    req    = '{8'h90, 8'h00, 8'h00, 8'h02};
    exp_tx = '{9'h000, 9'h012, 9'h00A, 9'h184};
    exp_wr = '{};
    exp_rd = '{20'h00000, 20'h00001, 20'h00002};
    run("rd3");
    chk("rd3_lat", first_vld - fe_cyc, 32'd6);

    // Native write 0x00100, 2 bytes
    req    = '{8'h80, 8'h01, 8'h00, 8'h01, 8'h0A, 8'h82};
    exp_tx = '{9'h100};
    exp_wr = '{{20'h00100, 8'h0A}, {20'h00101, 8'h82}};
    exp_rd = '{};
    run("wr2");
    chk("wr2_lat", first_vld - fe_cyc, 32'd4);

    // Same write while the register file is busy
    aux.REG_Busy = 1'b1;
    exp_tx = '{9'h120};
    exp_wr = '{};
    run("defer");
    aux.REG_Busy = 1'b0;

    // Write with one data byte too many
    req    = '{8'h80, 8'h01, 8'h00, 8'h01, 8'h0A, 8'h82, 8'h55};
    exp_tx = '{9'h110};
    run("wr_extra");

    // Read running past the last DPCD address
    req    = '{8'h90, 8'h0F, 8'hFE, 8'h03};
    run("rd_oob");

    // Read ending exactly on the last DPCD address
    req    = '{8'h90, 8'h0F, 8'hFC, 8'h03};
    exp_tx = '{9'h000, 9'h0E7, 9'h0EE, 9'h0F5, 9'h1FC};
    exp_rd = '{20'h00FFC, 20'h00FFD, 20'h00FFE, 20'h00FFF};
    run("rd_edge");
    exp_rd = '{};

    // I2C-over-AUX read
    req    = '{8'h10, 8'h00, 8'h50, 8'h00};
    exp_tx = '{9'h140};
    run("i2c");

    // Unsupported native command
    req    = '{8'hA0, 8'h00, 8'h00, 8'h00};
    exp_tx = '{9'h110};
    run("badcmd");

    // Read carrying a data byte
    req    = '{8'h90, 8'h00, 8'h00, 8'h00, 8'h33};
    run("rd_data");

    // Full 16-byte write, then one with 17 bytes
    req = '{8'h80, 8'h02, 8'h00, 8'h0F};
    exp_wr = '{};
    for (int i = 0; i < 16; i++) begin
      req.push_back(8'h30 + 8'(i));
      exp_wr.push_back({20'h00200 + 20'(i), 8'h30 + 8'(i)});
    end
    exp_tx = '{9'h100};
    run("wr16");
    req.push_back(8'h77);
    exp_tx = '{9'h110};
    exp_wr = '{};
    run("wr17");

    // Truncated header and a bare frame end: no reply
    req    = '{8'h90, 8'h00};
    exp_tx = '{};
    run("short");
    @(posedge clk); #1 aux.RX_Frame_End = 1'b1;
    @(posedge clk); #1 aux.RX_Frame_End = 1'b0;
    repeat (4) @(negedge clk);
    chk("bare_fe_ntx", tx_log.size(), 32'd0);
    chk("bare_fe_busy", {31'd0, aux.Resp_Busy}, 32'd0);

    // Read 2 bytes with RDY held low 5 cycles per byte
    aux.TX_Byte_RDY = 1'b0;
    req    = '{8'h90, 8'h00, 8'h00, 8'h01};
    exp_tx = '{9'h000, 9'h012, 9'h10A};
    exp_rd = '{20'h00000, 20'h00001};
    send();
    for (int k = 0; k < 3; k++)
      stall_byte("stall_hold");
    aux.TX_Byte_RDY = 1'b1;
    wait_idle();
    check_logs("stall");

    // Reset asserted while the reply is pending
    aux.TX_Byte_RDY = 1'b0;
    send();
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!aux.TX_Byte_VLD && n < 50);
      chk("rst_mid_vld", {31'd0, aux.TX_Byte_VLD}, 32'd1);
    end
    @(posedge clk); #1 reset_n = 1'b0;
    #1 check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    aux.TX_Byte_RDY = 1'b1;
    repeat (2) @(posedge clk);

    req    = '{8'h90, 8'h00, 8'h00, 8'h02};
    exp_tx = '{9'h000, 9'h012, 9'h00A, 9'h184};
    exp_rd = '{20'h00000, 20'h00001, 20'h00002};
    run("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
